// File: rtl/matrix_mult_4x4_complex_strassen.sv
// 4x4 signed complex matrix multiplier, C = A x B, one level of Strassen over
// 2x2 complex blocks (7 block products instead of 8). Registered result with
// exactly one cycle of latency, one result per cycle when in_valid is held.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears C and out_valid
//   in_valid   A/B operands valid this cycle
//   A_real/A_imag, B_real/B_imag   [row][col] signed w-bit operands
//   C_real/C_imag                  [row][col] signed (2w+3)-bit result
//   out_valid  C holds the product of the operands accepted last cycle
module matrix_mult_4x4_complex_strassen #(
    parameter int w = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic signed [w-1:0]   A_real [0:3][0:3],
    input  logic signed [w-1:0]   A_imag [0:3][0:3],
    input  logic signed [w-1:0]   B_real [0:3][0:3],
    input  logic signed [w-1:0]   B_imag [0:3][0:3],
    output logic signed [2*w+2:0] C_real [0:3][0:3],
    output logic signed [2*w+2:0] C_imag [0:3][0:3],
    output logic                  out_valid
);

    localparam int WIDTH_OUT = 2 * w + 3;

    typedef logic signed [w:0]           pre_t;
    typedef logic signed [WIDTH_OUT-1:0] acc_t;

    // Index [0] is the real part, [1] the imaginary part.
    pre_t pa  [0:1][0:3][0:3];
    pre_t pb  [0:1][0:3][0:3];
    pre_t lhs [0:1][0:6][0:1][0:1];
    pre_t rhs [0:1][0:6][0:1][0:1];
    acc_t m   [0:1][0:6][0:1][0:1];
    acc_t c   [0:1][0:3][0:3];

    // Sign-extend to w+1 bits, then form the Strassen pre-added block operands.
    // Sums/differences of two w-bit values always fit in w+1 bits.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                pa[0][r][k] = pre_t'(A_real[r][k]);
                pa[1][r][k] = pre_t'(A_imag[r][k]);
                pb[0][r][k] = pre_t'(B_real[r][k]);
                pb[1][r][k] = pre_t'(B_imag[r][k]);
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 2; k++) begin
                    lhs[p][0][r][k] = pa[p][r][k]   + pa[p][r+2][k+2]; // A11+A22
                    lhs[p][1][r][k] = pa[p][r+2][k] + pa[p][r+2][k+2]; // A21+A22
                    lhs[p][2][r][k] = pa[p][r][k];                     // A11
                    lhs[p][3][r][k] = pa[p][r+2][k+2];                 // A22
                    lhs[p][4][r][k] = pa[p][r][k]   + pa[p][r][k+2];   // A11+A12
                    lhs[p][5][r][k] = pa[p][r+2][k] - pa[p][r][k];     // A21-A11
                    lhs[p][6][r][k] = pa[p][r][k+2] - pa[p][r+2][k+2]; // A12-A22
                    rhs[p][0][r][k] = pb[p][r][k]   + pb[p][r+2][k+2]; // B11+B22
                    rhs[p][1][r][k] = pb[p][r][k];                     // B11
                    rhs[p][2][r][k] = pb[p][r][k+2] - pb[p][r+2][k+2]; // B12-B22
                    rhs[p][3][r][k] = pb[p][r+2][k] - pb[p][r][k];     // B21-B11
                    rhs[p][4][r][k] = pb[p][r+2][k+2];                 // B22
                    rhs[p][5][r][k] = pb[p][r][k]   + pb[p][r][k+2];   // B11+B12
                    rhs[p][6][r][k] = pb[p][r+2][k] + pb[p][r+2][k+2]; // B21+B22
                end
            end
        end
    end

    // Seven 2x2 complex block products, 4 real multiplies per complex product.
    // Carried at WIDTH_OUT bits; any wrap in intermediates cancels in the final sums.
    always_comb begin
        for (int n = 0; n < 7; n++) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    m[0][n][i][j] = '0;
                    m[1][n][i][j] = '0;
                    for (int k = 0; k < 2; k++) begin
                        m[0][n][i][j] = m[0][n][i][j]
                            + acc_t'(lhs[0][n][i][k]) * acc_t'(rhs[0][n][k][j])
                            - acc_t'(lhs[1][n][i][k]) * acc_t'(rhs[1][n][k][j]);
                        m[1][n][i][j] = m[1][n][i][j]
                            + acc_t'(lhs[0][n][i][k]) * acc_t'(rhs[1][n][k][j])
                            + acc_t'(lhs[1][n][i][k]) * acc_t'(rhs[0][n][k][j]);
                    end
                end
            end
        end
    end

    // Recombine: C11=M1+M4-M5+M7, C12=M3+M5, C21=M2+M4, C22=M1-M2+M3+M6.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    c[p][i][j]     = m[p][0][i][j] + m[p][3][i][j] - m[p][4][i][j]
                                   + m[p][6][i][j];
                    c[p][i][j+2]   = m[p][2][i][j] + m[p][4][i][j];
                    c[p][i+2][j]   = m[p][1][i][j] + m[p][3][i][j];
                    c[p][i+2][j+2] = m[p][0][i][j] - m[p][1][i][j] + m[p][2][i][j]
                                   + m[p][5][i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    C_real[i][j] <= '0;
                    C_imag[i][j] <= '0;
                end
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        C_real[i][j] <= c[0][i][j];
                        C_imag[i][j] <= c[1][i][j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_4x4_complex_strassen.sv
module tb_matrix_mult_4x4_complex_strassen;

    localparam int W  = 48;
    localparam int WO = 2 * W + 3;
    localparam int VW = 16 * WO;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_valid;
    logic signed [W-1:0]  ar [0:3][0:3];
    logic signed [W-1:0]  ai [0:3][0:3];
    logic signed [W-1:0]  br [0:3][0:3];
    logic signed [W-1:0]  bi [0:3][0:3];
    logic signed [WO-1:0] cr [0:3][0:3];
    logic signed [WO-1:0] ci [0:3][0:3];

    // Staged operands, copied onto the DUT inputs at the driving edge.
    logic signed [W-1:0] n_ar [0:3][0:3];
    logic signed [W-1:0] n_ai [0:3][0:3];
    logic signed [W-1:0] n_br [0:3][0:3];
    logic signed [W-1:0] n_bi [0:3][0:3];

    logic [VW-1:0] exp_r_q [$];
    logic [VW-1:0] exp_i_q [$];
    logic [VW-1:0] last_r = '0;
    logic [VW-1:0] last_i = '0;
    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    matrix_mult_4x4_complex_strassen #(.w(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A_real   (ar),
        .A_imag   (ai),
        .B_real   (br),
        .B_imag   (bi),
        .C_real   (cr),
        .C_imag   (ci),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Reference: direct definition of the complex matrix product in 128-bit arithmetic.
    task automatic push_expected();
        logic signed [127:0] sr, si, a, b, c, d;
        logic [VW-1:0] vr, vi;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                sr = 0;
                si = 0;
                for (int k = 0; k < 4; k++) begin
                    a = ar[i][k];
                    b = ai[i][k];
                    c = br[k][j];
                    d = bi[k][j];
                    sr = sr + a * c - b * d;
                    si = si + a * d + b * c;
                end
                vr[(i*4+j)*WO +: WO] = sr[WO-1:0];
                vi[(i*4+j)*WO +: WO] = si[WO-1:0];
            end
        end
        exp_r_q.push_back(vr);
        exp_i_q.push_back(vi);
    endtask

    task automatic drive(input bit v, input bit r);
        @(negedge clk);
        ar = n_ar;
        ai = n_ai;
        br = n_br;
        bi = n_bi;
        rst = r;
        in_valid = v;
        started = 1'b1;
        if (v && !r) push_expected();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                n_ar[i][j] = rnd48();
                n_ai[i][j] = rnd48();
                n_br[i][j] = rnd48();
                n_bi[i][j] = rnd48();
            end
        end
    endtask

    task automatic fill_const(input logic [W-1:0] va, vb, vc, vd);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                n_ar[i][j] = va;
                n_ai[i][j] = vb;
                n_br[i][j] = vc;
                n_bi[i][j] = vd;
            end
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, want, $time);
        end
    endtask

    task automatic cmp_mat(input string nm, input logic [VW-1:0] er, input logic [VW-1:0] ei);
        logic [WO-1:0] e;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                e = er[(i*4+j)*WO +: WO];
                checks++;
                if (cr[i][j] !== e) begin
                    errors++;
                    $display("FAIL %s C_real[%0d][%0d]: got %h expected %h at %0t",
                             nm, i, j, cr[i][j], e, $time);
                end
                e = ei[(i*4+j)*WO +: WO];
                checks++;
                if (ci[i][j] !== e) begin
                    errors++;
                    $display("FAIL %s C_imag[%0d][%0d]: got %h expected %h at %0t",
                             nm, i, j, ci[i][j], e, $time);
                end
            end
        end
    endtask

    // Monitor: each cycle, an output is due exactly when a vector was accepted
    // at the preceding edge; otherwise out_valid must be low and C must hold.
    always begin
        @(posedge clk);
        #1;
        if (started) begin
            if (rst) begin
                chk_bit("reset_out_valid", out_valid, 1'b0);
                last_r = '0;
                last_i = '0;
                cmp_mat("reset", last_r, last_i);
            end else if (exp_r_q.size() > 0) begin
                chk_bit("latency_out_valid", out_valid, 1'b1);
                last_r = exp_r_q.pop_front();
                last_i = exp_i_q.pop_front();
                cmp_mat("result", last_r, last_i);
            end else begin
                chk_bit("idle_out_valid", out_valid, 1'b0);
                cmp_mat("hold", last_r, last_i);
            end
        end
    end

    initial begin
        // Reset with in_valid high and random operands: nothing may be accepted.
        fill_random();
        drive(1'b1, 1'b1);
        fill_random();
        drive(1'b1, 1'b1);

        fill_random();
        drive(1'b1, 1'b0);

        // Identity A.
        fill_random();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                n_ar[i][j] = (i == j) ? 48'sd1 : 48'sd0;
                n_ai[i][j] = '0;
            end
        end
        drive(1'b1, 1'b0);

        // Pure imaginary identity A, constant B.
        fill_const(48'd0, 48'd0, 48'd5, 48'd3);
        for (int i = 0; i < 4; i++) n_ai[i][i] = 48'sd1;
        drive(1'b1, 1'b0);

        // Extremes.
        fill_const(48'h8000_0000_0000, 48'h8000_0000_0000,
                   48'h8000_0000_0000, 48'h8000_0000_0000);
        drive(1'b1, 1'b0);
        fill_const(48'h7FFF_FFFF_FFFF, 48'd0, 48'h7FFF_FFFF_FFFF, 48'd0);
        drive(1'b1, 1'b0);
        fill_const(48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF,
                   48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000);
        drive(1'b1, 1'b0);
        fill_const(48'd0, 48'd0, 48'd0, 48'd0);
        drive(1'b1, 1'b0);

        // Hold, then reassert.
        fill_random();
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);

        // Back-to-back random stream with one gap in the middle.
        for (int n = 0; n < 3300; n++) begin
            fill_random();
            if (n == 1650) begin
                drive(1'b0, 1'b0);
                drive(1'b0, 1'b0);
                drive(1'b0, 1'b0);
            end
            drive(1'b1, 1'b0);
        end

        // Mid-stream reset clears everything.
        fill_random();
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        fill_random();
        drive(1'b1, 1'b0);

        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_r_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never presented, expected 0", exp_r_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
